// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_ready,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_dm_req,
  input  logic                  i_dm_rw,
  input  logic [3:0]            i_dm_sel,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  output logic                  o_dm_ready,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic                  o_mem_access,
  output logic                  o_mem_rw,
  output logic [3:0]            o_mem_sel,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  output logic                  o_timeout_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_GRANT_D, S_GRANT_I, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_pick_d;
  logic                  w_pick_i;
  logic                  w_tout;
  logic                  w_in_grant;
  logic                  w_done;
  logic                  w_starved;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic                  r_gnt_d;
  logic                  r_rw;
  logic [3:0]            r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic [SW-1:0]         r_starve;
  logic [TW-1:0]         r_tcnt;
  logic                  r_timeout_err;

  assign w_in_grant = (r_state == S_GRANT_D) || (r_state == S_GRANT_I);
  assign w_starved  = (r_starve == SLIM);
  assign w_done     = w_in_grant && (i_mem_ready || w_tout);
  // A timed-out access returns zero instead of whatever is on the bus.
  assign w_rd_data  = i_mem_ready ? i_mem_rdata : '0;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Arbitration in IDLE, completion/timeout detection in the grant states
  always_comb begin
    w_next   = r_state;
    w_pick_d = 1'b0;
    w_pick_i = 1'b0;
    w_tout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_dm_req && !(w_starved && i_if_req)) begin
          w_pick_d = 1'b1;
          w_next   = S_GRANT_D;
        end else if (i_if_req) begin
          w_pick_i = 1'b1;
          w_next   = S_GRANT_I;
        end
      end
      S_GRANT_D, S_GRANT_I: begin
        if (i_mem_ready) begin
          w_next = S_RESP;
        end else if ((TIMEOUT != 0) && (r_tcnt == TLAST)) begin
          w_tout = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the winning request; the port is driven only from these registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt_d <= 1'b0;
      r_rw    <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_pick_d) begin
      r_gnt_d <= 1'b1;
      r_rw    <= i_dm_rw;
      r_sel   <= i_dm_sel;
      r_addr  <= i_dm_addr;
      r_wdata <= i_dm_wdata;
    end else if (w_pick_i) begin
      r_gnt_d <= 1'b0;
      r_rw    <= 1'b0;
      r_sel   <= 4'hF;
      r_addr  <= i_if_addr;
      r_wdata <= '0;
    end
  end

  // Fairness counter: consecutive data grants taken while a fetch was waiting
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve <= '0;
    end else if (w_pick_d) begin
      if (!i_if_req)     r_starve <= '0;
      else if (!w_starved) r_starve <= r_starve + SW'(1);
    end else if (w_pick_i) begin
      r_starve <= '0;
    end
  end

  // Hung-memory guard: counts grant cycles without mem_ready
  always_ff @(posedge i_clk) begin
    if (i_rst)                          r_tcnt <= '0;
    else if (w_pick_d || w_pick_i)      r_tcnt <= '0;
    else if (w_in_grant && !i_mem_ready) r_tcnt <= r_tcnt + TW'(1);
  end

  // Capture read data on completion; writes leave the data register alone
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_rdata    <= '0;
      r_dm_rdata    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_done && (r_state == S_GRANT_I))          r_if_rdata <= w_rd_data;
      if (w_done && (r_state == S_GRANT_D) && !r_rw) r_dm_rdata <= w_rd_data;
      if (w_tout)                                    r_timeout_err <= 1'b1;
    end
  end

  assign o_mem_access  = w_in_grant;
  assign o_mem_rw      = r_rw;
  assign o_mem_sel     = r_sel;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_if_ready    = (r_state == S_RESP) && !r_gnt_d;
  assign o_dm_ready    = (r_state == S_RESP) && r_gnt_d;
  assign o_if_rdata    = r_if_rdata;
  assign o_dm_rdata    = r_dm_rdata;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-schedule model
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SL = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_rw;
  logic [3:0]    dm_sel;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;
  logic          mem_access;
  logic          mem_rw;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_rw(dm_rw), .i_dm_sel(dm_sel), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata),
    .o_mem_access(mem_access), .o_mem_rw(mem_rw), .o_mem_sel(mem_sel),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_mem_ready(mem_ready), .o_timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int mode  = 0;

  // Transaction schedule: grant seen from edge g_e, completes at edge g_c,
  // ready pulse visible after edge g_c, next arbitration at edge free_at.
  bit          g_valid = 0;
  bit          g_is_d, g_tout, g_rw;
  int          g_e, g_c, free_at, starve;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, g_rdata;
  logic [3:0]  g_sel;
  bit          force_tout = 0;
  logic [DW-1:0] exp_if_rdata, exp_dm_rdata;
  bit          exp_terr;

  bit ifa, ifg, dma, dmg;
  int ifgap, dmgap;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive_req();
    if (ifa) begin
      if (ifg && mode == 0 && $urandom_range(0, 3) == 0) if_req = 1'b0;
    end else if (ifgap > 0) begin
      ifgap--;
    end else begin
      ifa = 1; ifg = 0; if_req = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (dma) begin
      if (dmg && mode == 0 && $urandom_range(0, 3) == 0) dm_req = 1'b0;
    end else if (dmgap > 0) begin
      dmgap--;
    end else begin
      dma = 1; dmg = 0; dm_req = 1'b1;
      dm_rw    = 1'($urandom_range(0, 1));
      dm_sel   = 4'($urandom_range(0, 15));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
  endtask

  task automatic step();
    bit in_win, exp_ifr, exp_dmr, win_d, win_i;
    int lat;
    @(posedge clk);
    cyc++;
    #1;
    if (g_valid && cyc == g_c) begin
      if (g_is_d) begin
        if (!g_rw) exp_dm_rdata = g_tout ? '0 : g_rdata;
      end else begin
        exp_if_rdata = g_tout ? '0 : g_rdata;
      end
      if (g_tout) exp_terr = 1;
    end
    in_win  = g_valid && cyc >= g_e && cyc < g_c;
    exp_ifr = g_valid && cyc == g_c && !g_is_d;
    exp_dmr = g_valid && cyc == g_c && g_is_d;
    check("mem_access", mem_access, in_win);
    if (in_win) begin
      check("mem_addr", mem_addr, g_addr);
      check("mem_sel", mem_sel, g_sel);
      check("mem_rw", mem_rw, g_rw);
      if (g_is_d && g_rw) check("mem_wdata", mem_wdata, g_wdata);
    end
    check("if_ready", if_ready, exp_ifr);
    check("dm_ready", dm_ready, exp_dmr);
    if (exp_ifr) check("if_rdata", if_rdata, exp_if_rdata);
    check("dm_rdata", dm_rdata, exp_dm_rdata);
    check("timeout_err", timeout_err, exp_terr);

    if (exp_ifr) begin ifa = 0; if_req = 1'b0; ifgap = (mode == 1) ? 0 : $urandom_range(0, 4); end
    if (exp_dmr) begin dma = 0; dm_req = 1'b0; dmgap = (mode == 1) ? 0 : $urandom_range(0, 4); end
    drive_req();

    if (cyc + 1 == free_at) begin
      win_d = dm_req && !(starve == SL && if_req);
      win_i = !win_d && if_req;
      if (win_d || win_i) begin
        g_valid = 1; g_is_d = win_d; g_e = cyc + 1;
        if (win_d) begin
          g_addr = dm_addr; g_sel = dm_sel; g_rw = dm_rw; g_wdata = dm_wdata; dmg = 1;
          starve = if_req ? ((starve < SL) ? starve + 1 : SL) : 0;
        end else begin
          g_addr = if_addr; g_sel = 4'hF; g_rw = 0; g_wdata = '0; ifg = 1;
          starve = 0;
        end
        g_tout = force_tout || (mode == 0 && $urandom_range(0, 15) == 0);
        force_tout = 0;
        lat = (mode == 1) ? 0 : $urandom_range(0, 3);
        g_c = g_tout ? g_e + TO : g_e + 1 + lat;
        g_rdata = $urandom;
        free_at = g_c + 2;
      end else begin
        free_at = cyc + 2;
      end
    end

    if (g_valid && !g_tout && cyc + 1 == g_c) begin
      mem_ready = 1'b1; mem_rdata = g_rdata;
    end else if (g_valid && cyc + 1 > g_e && cyc + 1 <= g_c) begin
      mem_ready = 1'b0; mem_rdata = $urandom;
    end else begin
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    ifa = 0; ifg = 0; dma = 0; dmg = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    check("rst_mem_access", mem_access, 1'b0);
    check("rst_if_ready", if_ready, 1'b0);
    check("rst_dm_ready", dm_ready, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_if_rdata", if_rdata, '0);
    check("rst_dm_rdata", dm_rdata, '0);
    check("rst_mem_addr", mem_addr, '0);
    rst = 1'b0;
    g_valid = 0; starve = 0; exp_if_rdata = '0; exp_dm_rdata = '0; exp_terr = 0;
    ifgap = 0; dmgap = 0;
    free_at = cyc + 2;
  endtask

  initial begin
    bit reached;
    if_addr = '0; dm_rw = 0; dm_sel = '0; dm_addr = '0; dm_wdata = '0;
    apply_reset();

    mode = 0;
    repeat (1500) step();
    mode = 1;
    repeat (300) step();

    mode = 0;
    force_tout = 1;
    reached = 0;
    for (int i = 0; i < 300 && !reached; i++) begin
      step();
      if (g_valid && g_tout && cyc == g_e + 3) reached = 1;
    end
    check("reach_mid_grant", reached, 1'b1);
    apply_reset();

    mode = 1;
    repeat (200) step();
    mode = 0;
    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
